// File: rtl/watchdog_gen_if.sv
// 68k bus signals the watchdog decodes to detect a kick write.
interface watchdog_gen_if;
  logic       nLDS;
  logic       RW;
  logic       A23I;
  logic       A22I;
  logic [4:0] M68K_ADDR_U;

  modport master (
    output nLDS,
    output RW,
    output A23I,
    output A22I,
    output M68K_ADDR_U
  );

  modport slave (
    input nLDS,
    input RW,
    input A23I,
    input A22I,
    input M68K_ADDR_U
  );
endinterface

// File: rtl/watchdog_gen.sv
// Parametrised system watchdog: counts synchronised WDCLK ticks, kicked by a 68k byte write,
// warns before tripping, then holds nRESET/nHALT low for HOLD_TICKS ticks; counts trips.
module watchdog_gen #(
  parameter int         CNT_W      = 4,
  parameter int         WARN_TICKS = 6,
  parameter int         TRIP_TICKS = 8,
  parameter int         HOLD_TICKS = 8,
  parameter logic [6:0] ADDR_MATCH = 7'b0011000,
  parameter logic [6:0] ADDR_MASK  = 7'b1111111,
  parameter int         TRIPCNT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 WDRESET,
  input  logic                 nRST,
  input  logic                 WDCLK,
  input  logic                 WD_EN,
  watchdog_gen_if.slave        bus,
  output logic                 nRESET,
  output logic                 nHALT,
  output logic                 nWARN,
  output logic [1:0]           STATE,
  output logic [TRIPCNT_W-1:0] TRIP_CNT
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WARN = 2'd1,
    ST_TRIP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WARN_C = CNT_W'(WARN_TICKS);
  localparam logic [CNT_W-1:0] TRIP_C = CNT_W'(TRIP_TICKS);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_TICKS);

  state_t               state;
  logic [CNT_W-1:0]     tick_cnt;
  logic [CNT_W-1:0]     hold_cnt;
  logic [CNT_W-1:0]     tick_inc;
  logic [CNT_W-1:0]     hold_inc;
  logic                 wd_s1, wd_s2, wd_s3;
  logic                 tick;
  logic                 kick;
  logic [6:0]           addr;

  // WDCLK is asynchronous: two flops for metastability, a third to find the rising edge
  always_ff @(posedge CLK or posedge WDRESET) begin
    if (WDRESET) begin
      wd_s1 <= 1'b0;
      wd_s2 <= 1'b0;
      wd_s3 <= 1'b0;
    end else begin
      wd_s1 <= WDCLK;
      wd_s2 <= wd_s1;
      wd_s3 <= wd_s2;
    end
  end

  assign tick     = wd_s2 & ~wd_s3;
  assign addr     = {bus.A23I, bus.A22I, bus.M68K_ADDR_U};
  assign kick     = nRST & ~bus.nLDS & ~bus.RW & (((addr ^ ADDR_MATCH) & ADDR_MASK) == 7'd0);
  assign tick_inc = tick_cnt + CNT_W'(1);
  assign hold_inc = hold_cnt + CNT_W'(1);

  always_ff @(posedge CLK or posedge WDRESET) begin
    if (WDRESET) begin
      state    <= ST_RUN;
      tick_cnt <= '0;
      hold_cnt <= '0;
      TRIP_CNT <= '0;
      nWARN    <= 1'b1;
    end else if (!nRST) begin
      // external reset request forces a hold that only starts counting once released
      state    <= ST_TRIP;
      hold_cnt <= '0;
      nWARN    <= 1'b1;
    end else begin
      case (state)
        ST_RUN, ST_WARN: begin
          if (!WD_EN) begin
            state    <= ST_RUN;
            tick_cnt <= '0;
            nWARN    <= 1'b1;
          end else if (kick) begin
            state    <= ST_RUN;
            tick_cnt <= '0;
            nWARN    <= 1'b1;
          end else if (tick) begin
            tick_cnt <= tick_inc;
            if (state == ST_RUN && tick_inc == WARN_C) begin
              state <= ST_WARN;
              nWARN <= 1'b0;
            end else if (state == ST_WARN && tick_inc == TRIP_C) begin
              state    <= ST_TRIP;
              hold_cnt <= '0;
              nWARN    <= 1'b1;
              if (TRIP_CNT != {TRIPCNT_W{1'b1}}) begin
                TRIP_CNT <= TRIP_CNT + TRIPCNT_W'(1);
              end
            end
          end
        end
        ST_TRIP: begin
          nWARN <= 1'b1;
          if (tick) begin
            if (hold_inc == HOLD_C) begin
              state    <= ST_RUN;
              tick_cnt <= '0;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_inc;
            end
          end
        end
        default: begin
          state    <= ST_RUN;
          tick_cnt <= '0;
          nWARN    <= 1'b1;
        end
      endcase
    end
  end

  assign STATE  = state;
  assign nRESET = nRST & (state != ST_TRIP);
  assign nHALT  = nRESET;

endmodule

// File: tb/tb_watchdog_gen.sv
// Directed bench: default-parameter instance plus a small (WARN=2, TRIP=3, HOLD=1, TRIPCNT_W=2) instance.
module tb_watchdog_gen;
  logic       CLK;
  logic       WDCLK;
  logic       wdreset, nrst, wd_en;
  logic       nreset, nhalt, nwarn;
  logic [1:0] state;
  logic [7:0] trip_cnt;
  logic       wdreset2, nrst2, wd_en2;
  logic       nreset2, nhalt2, nwarn2;
  logic [1:0] state2;
  logic [1:0] trip_cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  watchdog_gen_if bus ();
  watchdog_gen_if bus2 ();

  watchdog_gen u_def (
    .CLK(CLK), .WDRESET(wdreset), .nRST(nrst), .WDCLK(WDCLK), .WD_EN(wd_en),
    .bus(bus), .nRESET(nreset), .nHALT(nhalt), .nWARN(nwarn),
    .STATE(state), .TRIP_CNT(trip_cnt)
  );

  watchdog_gen #(
    .CNT_W(2), .WARN_TICKS(2), .TRIP_TICKS(3), .HOLD_TICKS(1), .TRIPCNT_W(2)
  ) u_sm (
    .CLK(CLK), .WDRESET(wdreset2), .nRST(nrst2), .WDCLK(WDCLK), .WD_EN(wd_en2),
    .bus(bus2), .nRESET(nreset2), .nHALT(nhalt2), .nWARN(nwarn2),
    .STATE(state2), .TRIP_CNT(trip_cnt2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    string      name;
    logic       nlds;
    logic       rw;
    logic       a23;
    logic       a22;
    logic [4:0] au;
    logic [1:0] exp_state;
    logic       exp_nwarn;
  } dec_vec_t;

  typedef struct {
    logic [1:0] exp_state;
    logic       exp_nwarn;
    logic       exp_nreset;
    logic [7:0] exp_tcnt;
  } trip_vec_t;

  dec_vec_t  dec_tab [8];
  trip_vec_t trip_tab [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    bus.nLDS = 1'b1; bus.RW = 1'b1; bus.A23I = 1'b0; bus.A22I = 1'b0; bus.M68K_ADDR_U = 5'd0;
  endtask

  task automatic bus_kick_drive();
    bus.nLDS = 1'b0; bus.RW = 1'b0; bus.A23I = 1'b0; bus.A22I = 1'b0; bus.M68K_ADDR_U = 5'b11000;
  endtask

  task automatic kick_once();
    bus_kick_drive();
    step();
    bus_idle();
  endtask

  // one WDCLK period of 16 CLK; the tick acts on the 3rd CLK edge after the rise
  task automatic wd_tick();
    WDCLK = 1'b1;
    repeat (8) step();
    WDCLK = 1'b0;
    repeat (8) step();
  endtask

  // kick asserted exactly in the cycle where the synchronised tick is high
  task automatic wd_tick_kick();
    WDCLK = 1'b1;
    step();
    step();
    bus_kick_drive();
    step();
    bus_idle();
    repeat (5) step();
    WDCLK = 1'b0;
    repeat (8) step();
  endtask

  task automatic reset_def();
    wdreset = 1'b1;
    step();
    wdreset = 1'b0;
    step();
  endtask

  initial begin
    WDCLK = 1'b0;
    wdreset = 1'b1; nrst = 1'b1; wd_en = 1'b1;
    wdreset2 = 1'b1; nrst2 = 1'b1; wd_en2 = 1'b1;
    bus_idle();
    bus2.nLDS = 1'b1; bus2.RW = 1'b1; bus2.A23I = 1'b0; bus2.A22I = 1'b0; bus2.M68K_ADDR_U = 5'd0;

    dec_tab[0] = '{"wr_300001",  1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 2'd0, 1'b1};
    dec_tab[1] = '{"rd_300001",  1'b0, 1'b1, 1'b0, 1'b0, 5'b11000, 2'd1, 1'b0};
    dec_tab[2] = '{"wr_320001",  1'b0, 1'b0, 1'b0, 1'b0, 5'b11001, 2'd1, 1'b0};
    dec_tab[3] = '{"lds_high",   1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, 2'd1, 1'b0};
    dec_tab[4] = '{"wr_b00001",  1'b0, 1'b0, 1'b1, 1'b0, 5'b11000, 2'd1, 1'b0};
    dec_tab[5] = '{"wr_700001",  1'b0, 1'b0, 1'b0, 1'b1, 5'b11000, 2'd1, 1'b0};
    dec_tab[6] = '{"wr_380001",  1'b0, 1'b0, 1'b0, 1'b0, 5'b11100, 2'd1, 1'b0};
    dec_tab[7] = '{"wr_310001",  1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 2'd0, 1'b1};

    // default trip sequence: warn at tick 6, trip at tick 8, release 8 ticks later
    for (int i = 0; i < 16; i++) begin
      int t;
      t = i + 1;
      if (t < 6)       trip_tab[i] = '{2'd0, 1'b1, 1'b1, 8'd0};
      else if (t < 8)  trip_tab[i] = '{2'd1, 1'b0, 1'b1, 8'd0};
      else if (t < 16) trip_tab[i] = '{2'd2, 1'b1, 1'b0, 8'd1};
      else             trip_tab[i] = '{2'd0, 1'b1, 1'b1, 8'd1};
    end

    // reset state, with nRESET following nRST while WDRESET is held
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_nwarn", 32'(nwarn), 1);
    chk("rst_tripcnt", 32'(trip_cnt), 0);
    chk("rst_nreset", 32'(nreset), 1);
    chk("rst_nhalt", 32'(nhalt), 1);
    nrst = 1'b0;
    #1;
    chk("rst_nreset_follow", 32'(nreset), 0);
    nrst = 1'b1;
    step();
    wdreset = 1'b0;
    wdreset2 = 1'b0;
    step();

    // unkicked trip sequence
    for (int i = 0; i < 16; i++) begin
      wd_tick();
      chk($sformatf("seq_state_t%0d", i + 1), 32'(state), 32'(trip_tab[i].exp_state));
      chk($sformatf("seq_nwarn_t%0d", i + 1), 32'(nwarn), 32'(trip_tab[i].exp_nwarn));
      chk($sformatf("seq_nreset_t%0d", i + 1), 32'(nreset), 32'(trip_tab[i].exp_nreset));
      chk($sformatf("seq_nhalt_t%0d", i + 1), 32'(nhalt), 32'(trip_tab[i].exp_nreset));
      chk($sformatf("seq_tcnt_t%0d", i + 1), 32'(trip_cnt), 32'(trip_tab[i].exp_tcnt));
    end

    // periodic kicks every 5 ticks keep it in RUN
    reset_def();
    for (int k = 0; k < 4; k++) begin
      repeat (5) wd_tick();
      kick_once();
      chk("kick5_state", 32'(state), 0);
      chk("kick5_nwarn", 32'(nwarn), 1);
    end
    chk("kick5_tcnt", 32'(trip_cnt), 0);

    // address/strobe decode from WARN
    for (int v = 0; v < 8; v++) begin
      reset_def();
      repeat (6) wd_tick();
      chk({dec_tab[v].name, "_pre"}, 32'(state), 1);
      bus.nLDS = dec_tab[v].nlds;
      bus.RW = dec_tab[v].rw;
      bus.A23I = dec_tab[v].a23;
      bus.A22I = dec_tab[v].a22;
      bus.M68K_ADDR_U = dec_tab[v].au;
      step();
      bus_idle();
      chk({dec_tab[v].name, "_state"}, 32'(state), 32'(dec_tab[v].exp_state));
      chk({dec_tab[v].name, "_nwarn"}, 32'(nwarn), 32'(dec_tab[v].exp_nwarn));
    end

    // kick in WARN after tick 7 clears the counter
    reset_def();
    repeat (7) wd_tick();
    chk("warn7_state", 32'(state), 1);
    kick_once();
    chk("warn7_kick_state", 32'(state), 0);
    chk("warn7_kick_nwarn", 32'(nwarn), 1);
    repeat (5) wd_tick();
    chk("warn7_after5", 32'(state), 0);
    wd_tick();
    chk("warn7_after6", 32'(state), 1);

    // kick coincident with tick: the kick wins
    reset_def();
    repeat (3) wd_tick();
    wd_tick_kick();
    repeat (5) wd_tick();
    chk("coinc_after5", 32'(state), 0);
    wd_tick();
    chk("coinc_after6", 32'(state), 1);

    // nRST low for 3 ticks, then 8 ticks of hold with ignored kicks
    reset_def();
    repeat (2) wd_tick();
    nrst = 1'b0;
    #1;
    chk("nrst_nreset_now", 32'(nreset), 0);
    chk("nrst_nhalt_now", 32'(nhalt), 0);
    step();
    chk("nrst_state", 32'(state), 2);
    repeat (3) wd_tick();
    chk("nrst_tcnt", 32'(trip_cnt), 0);
    nrst = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      wd_tick();
      if (t < 8) begin
        kick_once();
        chk($sformatf("nrst_hold_t%0d", t), 32'(nreset), 0);
      end else begin
        chk("nrst_release", 32'(nreset), 1);
        chk("nrst_release_state", 32'(state), 0);
      end
    end

    // WD_EN low suspends counting
    reset_def();
    wd_en = 1'b0;
    for (int t = 0; t < 20; t++) begin
      wd_tick();
      chk("dis_state", 32'(state), 0);
      chk("dis_nwarn", 32'(nwarn), 1);
    end
    wd_en = 1'b1;
    repeat (6) wd_tick();
    chk("en_warn", 32'(state), 1);
    wd_en = 1'b0;
    step();
    chk("dis_from_warn_state", 32'(state), 0);
    chk("dis_from_warn_nwarn", 32'(nwarn), 1);
    wd_en = 1'b1;
    repeat (8) wd_tick();
    chk("en_trip", 32'(state), 2);
    wd_en = 1'b0;
    repeat (7) wd_tick();
    chk("dis_trip_hold", 32'(state), 2);
    wd_tick();
    chk("dis_trip_done", 32'(state), 0);
    wd_en = 1'b1;

    // small instance: warn at 2, trip at 3, release after 1
    wdreset2 = 1'b1;
    step();
    wdreset2 = 1'b0;
    step();
    wd_tick();
    chk("sm_t1_state", 32'(state2), 0);
    wd_tick();
    chk("sm_t2_state", 32'(state2), 1);
    chk("sm_t2_nwarn", 32'(nwarn2), 0);
    wd_tick();
    chk("sm_t3_state", 32'(state2), 2);
    chk("sm_t3_nreset", 32'(nreset2), 0);
    chk("sm_t3_nhalt", 32'(nhalt2), 0);
    chk("sm_t3_tcnt", 32'(trip_cnt2), 1);
    wd_tick();
    chk("sm_t4_state", 32'(state2), 0);
    chk("sm_t4_nreset", 32'(nreset2), 1);
    for (int n = 2; n <= 5; n++) begin
      repeat (3) wd_tick();
      chk($sformatf("sm_trip%0d_state", n), 32'(state2), 2);
      chk($sformatf("sm_trip%0d_tcnt", n), 32'(trip_cnt2), (n > 3) ? 3 : n);
      wd_tick();
    end

    // async reset in the middle of a TRIP
    repeat (3) wd_tick();
    chk("sm_mid_trip", 32'(state2), 2);
    wdreset2 = 1'b1;
    #1;
    chk("sm_wdrst_state", 32'(state2), 0);
    chk("sm_wdrst_tcnt", 32'(trip_cnt2), 0);
    chk("sm_wdrst_nreset", 32'(nreset2), 1);
    chk("sm_wdrst_nwarn", 32'(nwarn2), 1);
    step();
    wdreset2 = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/watchdog_gen.md
Name: watchdog_gen

Overview:
Parametrised next-generation system watchdog for the NeoGeo core. It counts ticks of the slow watchdog clock WDCLK and is kicked by a 68k byte write to a decoded address. It raises an early-warning interrupt before tripping, then drives the open-collector-style nRESET/nHALT low for a programmable number of ticks. It also counts trips for debug and sits alongside the I/O sync logic in place of the fixed 4-bit watchdog.

Parameters:
CNT_W, 4, width of the tick and hold counters; must hold TRIP_TICKS and HOLD_TICKS.
WARN_TICKS, 6, ticks without a kick before nWARN asserts; must be in 1..TRIP_TICKS-1.
TRIP_TICKS, 8, ticks without a kick before the trip.
HOLD_TICKS, 8, ticks nRESET stays low after a trip or after nRST release; must be ≥1.
ADDR_MATCH, 7'b0011000, kick address compare value for {A23I,A22I,A21..A17}.
ADDR_MASK, 7'b1111111, per-bit compare enable; 0 = don't care.
TRIPCNT_W, 8, width of the saturating trip counter.

Ports:
CLK  in  1  system clock (mclk domain)
WDRESET  in  1  asynchronous active-high reset of the block
nRST  in  1  external reset request, active-low; synchronous to CLK
WDCLK  in  1  watchdog tick clock, asynchronous to CLK
WD_EN  in  1  1 = watchdog armed; 0 = counting suspended
nLDS  in  1  68k lower data strobe, active-low
RW  in  1  68k read/write; 0 = write
A23I  in  1  decoded address bit 23
A22I  in  1  decoded address bit 22
M68K_ADDR_U  in  5  68k address bits [21:17]
nRESET  out  1  system reset, active-low
nHALT  out  1  68k halt, active-low; identical to nRESET
nWARN  out  1  early-warning interrupt, active-low level
STATE  out  2  0 = RUN, 1 = WARN, 2 = TRIP; 3 is unused
TRIP_CNT  out  TRIPCNT_W  number of watchdog trips, saturating

Behaviour:
- Reset (WDRESET high, async) sets:
  - STATE = RUN, tick counter = 0, hold counter = 0;
  - synchroniser flops = 0, TRIP_CNT = 0, nWARN = 1;
  - nRESET = nRST.
- Tick generation:
  - WDCLK passes through two synchroniser flops s1, s2, then edge register s3.
  - tick = s2 & ~s3, one CLK wide.
  - tick is high on the 3rd CLK edge after WDCLK rises, counting the first edge that samples it high into s1.
- Kick (combinational, acted on at the CLK edge):
  - kick = nRST & ~nLDS & ~RW & (((addr ^ ADDR_MATCH) & ADDR_MASK) == 0), where addr = {A23I,A22I,M68K_ADDR_U}.
  - A kick held for several cycles acts on every cycle.
- RUN:
  - kick: tick counter <= 0.
  - tick without kick: counter + 1.
  - When the incremented value equals WARN_TICKS: go to WARN.
- WARN:
  - nWARN = 0.
  - kick: counter <= 0, go to RUN, nWARN = 1 from the next cycle.
  - tick without kick: counter + 1.
  - When the incremented value equals TRIP_TICKS: go to TRIP, hold counter <= 0, TRIP_CNT + 1 (saturates at all-ones).
- TRIP:
  - nRESET = nHALT = 0; kicks are ignored; nWARN = 1.
  - Each tick increments the hold counter.
  - When the incremented value equals HOLD_TICKS: go to RUN, tick counter <= 0.
- Kick and tick in the same cycle: the kick wins and the counter is cleared.
- nRST low, sampled at any CLK edge, in any state:
  - STATE <= TRIP, hold counter <= 0; the hold counter is held at 0 while nRST stays low.
  - TRIP_CNT is not incremented.
  - After nRST goes high, HOLD_TICKS further ticks elapse before release.
- WD_EN low:
  - In RUN or WARN: STATE <= RUN, tick counter held at 0, nWARN = 1.
  - A TRIP in progress completes normally.
  - nRST handling is unaffected.
- nRESET = nRST & (STATE != TRIP), combinational; nRESET therefore follows nRST low with zero latency.
- nHALT = nRESET.
- nWARN is registered and equals ~(STATE == WARN).
- With defaults, a trip occurs 8 unkicked ticks after the last kick, the same timing as the legacy fixed watchdog.

Test Plan:
1. Defaults, WD_EN=1, WDCLK period 16 CLK, no kicks → 6th tick: STATE=1, nWARN=0; 8th tick: STATE=2, nRESET=nHALT=0, TRIP_CNT=1; 8 ticks later: STATE=0, nRESET=1.
2. Write (nLDS=0, RW=0) to 0x300001 after every 5th tick → STATE stays 0, nWARN stays 1, TRIP_CNT stays 0. A read (RW=1) to the same address, or a write to 0x320001, does not kick.
3. Kick arriving in WARN after tick 7 → next cycle STATE=0, nWARN=1, counter=0. Kick coincident with a tick → counter reads 0, not 1.
4. nRST low for 3 ticks while in RUN → nRESET=0 in the same cycle, STATE=2, TRIP_CNT unchanged; release → nRESET returns to 1 exactly 8 ticks after nRST rises. Kicks during TRIP have no effect.
5. TRIPCNT_W=2, force 5 trips → TRIP_CNT=3 (saturated). Assert WDRESET mid-TRIP → immediately STATE=0, TRIP_CNT=0, nRESET=nRST, nWARN=1.
6. WD_EN=0 for 20 ticks → no WARN and no TRIP. Parameter set WARN=2, TRIP=3, HOLD=1, CNT_W=2 → nWARN=0 at tick 2, trip at tick 3, release 1 tick later.
